// File: rtl/priority_decoder_seq_pkg.sv
// Shared definitions for the priority encoder/decoder family: word layout,
// decoder FSM states and the index-to-one-hot decode.
package priority_decoder_seq_pkg;

  localparam int NONE_BIT = 2;
  localparam int Y_MSB    = 1;
  localparam int Y_LSB    = 0;
  localparam int WORD_W   = 3;

  // Stored word: {none, y[1:0]}
  typedef logic [WORD_W-1:0] code_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // A blank word (none=1) decodes to all-zero regardless of its index.
  function automatic logic [3:0] decode(input code_word_t w);
    return w[NONE_BIT] ? 4'b0000 : 4'(4'b0001 << w[Y_MSB:Y_LSB]);
  endfunction

endpackage

// File: rtl/priority_decoder_seq_if.sv
// Valid/ready link carrying encoded words from the priority encoder front end.
interface priority_decoder_seq_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_y;
  logic       in_none;

  modport master (output in_valid, in_y, in_none, input in_ready);
  modport slave  (input in_valid, in_y, in_none, output in_ready);

endinterface

// File: rtl/priority_decoder_seq_code_fifo.sv
// Small word buffer between the handshake and the replay FSM.
// Power-of-two depth so the pointers wrap naturally; flush beats push and pop.
module priority_decoder_seq_code_fifo
  import priority_decoder_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  code_word_t       push_data,
  input  logic             pop,
  output code_word_t       pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  code_word_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; the count guards every read, so stale
  // contents are never observed and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/priority_decoder_seq.sv
// Receive side of the priority-encoder link: buffers encoded words and replays
// each as a one-hot select held for HOLD_CYCLES cycles, back-to-back when queued.
module priority_decoder_seq
  import priority_decoder_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  priority_decoder_seq_if.slave  bus,
  output logic [3:0]             out_onehot,
  output logic                   out_active,
  output logic [CNT_W-1:0]       fifo_count
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  code_word_t in_word;
  code_word_t head_word;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       load_word;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] onehot_q, onehot_d;
  logic       active_q, active_d;

  // Ready looks only at registered fullness: no pass-through when full.
  assign bus.in_ready = !full && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign in_word      = {bus.in_none, bus.in_y};

  priority_decoder_seq_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (in_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // A new word is taken from idle, or on the last hold cycle of the current one.
  assign load_word = !flush && !empty && (state_q == ST_IDLE || hold_q == '0);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    onehot_d = onehot_q;
    active_d = active_q;
    pop      = 1'b0;
    if (flush) begin
      state_d  = ST_IDLE;
      hold_d   = '0;
      onehot_d = '0;
      active_d = 1'b0;
    end else if (load_word) begin
      pop      = 1'b1;
      state_d  = ST_HOLD;
      hold_d   = HOLD_LOAD;
      onehot_d = decode(head_word);
      active_d = 1'b1;
    end else if (state_q == ST_HOLD) begin
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else begin
        state_d  = ST_IDLE;
        onehot_d = '0;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      onehot_q <= onehot_d;
      active_q <= active_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_active = active_q;

endmodule
